// File: rtl/vram_brush_painter.sv
// -----------------------------------------------------------------------------
// vram_brush_painter
//
// Turns FT6206 touch events into VRAM write bursts that paint a square brush
// cell at the touch location. The whole VRAM is swept to BLACK after reset and
// whenever a clear is requested. The ILI9341 display controller reads the same
// VRAM on its own read port; this block only owns the write port.
//
// Optional feature macro: VRAM_BRUSH_PAINTER_ERASE_EN
//   When defined, an 'erase' input is added. An erasing touch paints BLACK, and
//   the erase bit takes part in the repeat-cell filter so erasing over a
//   just-painted cell still repaints it.
//
// Ports:
//   clk           sole clock
//   rstb          asynchronous active-low reset
//   ena           advance enable; low freezes all state and counters
//   touch         current touch event {valid, x, y}
//   brush_color   paint colour, sampled when a touch is captured
//   clear         single-cycle clear request
//   erase         (ERASE_EN only) paint BLACK instead of brush_color
//   vram_wr_ena   VRAM write strobe (registered)
//   vram_wr_addr  VRAM write address y*DISPLAY_WIDTH + x (registered)
//   vram_wr_data  VRAM write data (registered)
//   busy          high while sweeping or painting
// -----------------------------------------------------------------------------

package vram_brush_painter_pkg;
  // 9-bit coordinates cover the 320-row panel and leave room for the
  // out-of-range values the touch controller can report.
  localparam int COORD_W = 9;

  typedef logic [15:0] ILI9341_color_t;

  localparam ILI9341_color_t BLACK = 16'h0000;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } touch_t;
endpackage

// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | sweeping BLACK over every VRAM address, one per enabled cycle
// S_IDLE  | waiting for a clear request or a new in-range touch cell
// S_PAINT | emitting the pixels of the captured brush cell, dx fastest
module vram_brush_painter
  import vram_brush_painter_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int BRUSH_LOG2     = 2
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      ena,
  input  touch_t                    touch,
  input  ILI9341_color_t            brush_color,
  input  logic                      clear,
`ifdef VRAM_BRUSH_PAINTER_ERASE_EN
  input  logic                      erase,
`endif
  output logic                      vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
  output ILI9341_color_t            vram_wr_data,
  output logic                      busy
);

  localparam int ADDR_W = $clog2(VRAM_L);
  localparam int CELL_W = COORD_W - BRUSH_LOG2;
`ifdef VRAM_BRUSH_PAINTER_ERASE_EN
  localparam int KEY_W  = 2 * CELL_W + 1;
`else
  localparam int KEY_W  = 2 * CELL_W;
`endif

  // Limits are one bit wider than a coordinate so base+offset never wraps
  // before the range compare.
  localparam logic [COORD_W:0]    X_LIM      = (COORD_W + 1)'(DISPLAY_WIDTH);
  localparam logic [COORD_W:0]    Y_LIM      = (COORD_W + 1)'(DISPLAY_HEIGHT);
  localparam logic [ADDR_W-1:0]   SWEEP_LAST = ADDR_W'(VRAM_L - 1);
  localparam logic [ADDR_W-1:0]   ROW_PITCH  = ADDR_W'(DISPLAY_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_PAINT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     sweep_q, sweep_d;
  logic [BRUSH_LOG2-1:0] dx_q, dx_d;
  logic [BRUSH_LOG2-1:0] dy_q, dy_d;
  logic [COORD_W-1:0]    base_x_q, base_x_d;
  logic [COORD_W-1:0]    base_y_q, base_y_d;
  ILI9341_color_t        color_q, color_d;
  logic [KEY_W-1:0]      last_key_q, last_key_d;
  logic                  last_valid_q, last_valid_d;
  logic                  pending_q, pending_d;
  logic                  wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  ILI9341_color_t        wr_data_q, wr_data_d;

  // Current brush pixel and its VRAM address.
  logic [COORD_W:0]      px, py;
  logic                  pix_in;
  logic [ADDR_W-1:0]     pix_addr;

  // Touch decode: in-range check, cell key for the repeat filter, cell origin.
  logic                  touch_in;
  logic                  touch_repeat;
  logic [KEY_W-1:0]      touch_key;
  logic [COORD_W-1:0]    cell_x, cell_y;
  ILI9341_color_t        cap_color;

  assign px     = {1'b0, base_x_q} + (COORD_W + 1)'(dx_q);
  assign py     = {1'b0, base_y_q} + (COORD_W + 1)'(dy_q);
  assign pix_in = (px < X_LIM) && (py < Y_LIM);

  // Only in-range pixels are written, so py*W+px < VRAM_L and the product
  // fits the address width without losing any bits.
  assign pix_addr = ADDR_W'(py) * ROW_PITCH + ADDR_W'(px);

  assign touch_in = ({1'b0, touch.x} < X_LIM) && ({1'b0, touch.y} < Y_LIM);
  assign cell_x   = {touch.x[COORD_W-1:BRUSH_LOG2], {BRUSH_LOG2{1'b0}}};
  assign cell_y   = {touch.y[COORD_W-1:BRUSH_LOG2], {BRUSH_LOG2{1'b0}}};

`ifdef VRAM_BRUSH_PAINTER_ERASE_EN
  assign touch_key = {touch.x[COORD_W-1:BRUSH_LOG2],
                      touch.y[COORD_W-1:BRUSH_LOG2], erase};
  assign cap_color = erase ? BLACK : brush_color;
`else
  assign touch_key = {touch.x[COORD_W-1:BRUSH_LOG2],
                      touch.y[COORD_W-1:BRUSH_LOG2]};
  assign cap_color = brush_color;
`endif

  assign touch_repeat = last_valid_q && (last_key_q == touch_key);

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    color_d      = color_q;
    last_key_d   = last_key_q;
    last_valid_d = last_valid_q;
    // A clear pulse is remembered in every state, even while frozen, so it is
    // never lost; the sweep itself retires it when it finishes.
    pending_d    = pending_q | clear;
    wr_ena_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (ena) begin
      unique case (state_q)
        S_CLEAR: begin
          wr_ena_d  = 1'b1;
          wr_addr_d = sweep_q;
          wr_data_d = BLACK;
          if (sweep_q == SWEEP_LAST) begin
            sweep_d      = '0;
            pending_d    = 1'b0;
            last_valid_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end

        S_IDLE: begin
          if (clear || pending_q) begin
            sweep_d = '0;
            state_d = S_CLEAR;
          end else if (!touch.valid) begin
            last_valid_d = 1'b0;
          end else if (touch_in && !touch_repeat) begin
            base_x_d     = cell_x;
            base_y_d     = cell_y;
            color_d      = cap_color;
            last_key_d   = touch_key;
            last_valid_d = 1'b1;
            dx_d         = '0;
            dy_d         = '0;
            state_d      = S_PAINT;
          end
        end

        S_PAINT: begin
          // Clipped pixels still consume a cycle so the burst length is fixed.
          if (pix_in) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = pix_addr;
            wr_data_d = color_q;
          end
          if (&dx_q) begin
            dx_d = '0;
            if (&dy_q) begin
              dy_d    = '0;
              state_d = S_IDLE;
            end else begin
              dy_d = dy_q + 1'b1;
            end
          end else begin
            dx_d = dx_q + 1'b1;
          end
        end

        default: begin
          sweep_d = '0;
          state_d = S_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_CLEAR;
      sweep_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      color_q      <= BLACK;
      last_key_q   <= '0;
      last_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      wr_ena_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= BLACK;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      color_q      <= color_d;
      last_key_q   <= last_key_d;
      last_valid_q <= last_valid_d;
      pending_q    <= pending_d;
      wr_ena_q     <= wr_ena_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vram_brush_painter.sv
// -----------------------------------------------------------------------------
// tb_vram_brush_painter
//
// Bench for vram_brush_painter. The DUT is built with a short panel (240x40)
// so full BLACK sweeps stay cheap; the 240-pixel row pitch is kept so the
// reference addresses (4808, 4812, ...) are unchanged. Observed writes are
// collected by a monitor and compared against an expected write stream built
// from the painting rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vram_brush_painter;
  import vram_brush_painter_pkg::*;

  localparam int W      = 240;
  localparam int H      = 40;
  localparam int VL     = W * H;
  localparam int B      = 2;
  localparam int EDGE   = 1 << B;
  localparam int ADDR_W = $clog2(VL);
  localparam int SETTLE = VL + 150;

  logic                clk = 1'b0;
  logic                rstb = 1'b0;
  logic                ena = 1'b0;
  logic                clear = 1'b0;
  logic                erase = 1'b0;
  touch_t              touch;
  ILI9341_color_t      brush_color;
  logic                vram_wr_ena;
  logic [ADDR_W-1:0]   vram_wr_addr;
  ILI9341_color_t      vram_wr_data;
  logic                busy;

  vram_brush_painter #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .BRUSH_LOG2    (B)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .touch       (touch),
    .brush_color (brush_color),
    .clear       (clear),
`ifdef VRAM_BRUSH_PAINTER_ERASE_EN
    .erase       (erase),
`endif
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int obs_a[$];
  int obs_d[$];
  int exp_a[$];
  int exp_d[$];

  // Reference state: the last painted cell as seen by the repeat filter.
  bit m_lv = 1'b0;
  int m_cx = 0;
  int m_cy = 0;
  bit m_er = 1'b0;

  typedef struct {
    bit v;
    int x;
    int y;
    int col;
    int hold;
    int exp_n;
    int exp_first;
  } vec_t;

  vec_t vecs[11];

  always @(posedge clk) begin
    #1;
    if (rstb && vram_wr_ena) begin
      obs_a.push_back(int'(vram_wr_addr));
      obs_d.push_back(int'(vram_wr_data));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void add_paint(input int x, input int y, input int col);
    int bx, by;
    bx = (x / EDGE) * EDGE;
    by = (y / EDGE) * EDGE;
    for (int dy = 0; dy < EDGE; dy++)
      for (int dx = 0; dx < EDGE; dx++)
        if (bx + dx < W && by + dy < H) begin
          exp_a.push_back((by + dy) * W + bx + dx);
          exp_d.push_back(col);
        end
  endfunction

  function automatic void add_sweep();
    for (int i = 0; i < VL; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(0);
    end
  endfunction

  function automatic void model_touch(input bit v, input int x, input int y,
                                      input int col, input bit er);
    int cx, cy;
    if (!v) begin
      m_lv = 1'b0;
    end else if (x < W && y < H) begin
      cx = x / EDGE;
      cy = y / EDGE;
      if (!(m_lv && cx == m_cx && cy == m_cy && er == m_er)) begin
        add_paint(x, y, er ? 0 : col);
        m_lv = 1'b1;
        m_cx = cx;
        m_cy = cy;
        m_er = er;
      end
    end
  endfunction

  task automatic drive_touch(input bit v, input int x, input int y,
                             input int col, input bit er);
    touch.valid = v;
    touch.x     = COORD_W'(x);
    touch.y     = COORD_W'(y);
    brush_color = ILI9341_color_t'(col);
    erase       = er;
  endtask

  task automatic check_stream(input string name);
    int n, bad;
    check({name, "_count"}, obs_a.size(), exp_a.size());
    n   = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    bad = -1;
    for (int i = 0; i < n; i++)
      if (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]) begin
        bad = i;
        break;
      end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_content index %0d actual addr=%0d data=%h required addr=%0d data=%h",
               name, bad, obs_a[bad], obs_d[bad], exp_a[bad], exp_d[bad]);
    end
    obs_a.delete();
    obs_d.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (obs_a.size() < n && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check({name, "_reached"}, int'(obs_a.size() >= n), 1);
  endtask

  task automatic run_enabled(input int n_en, input int budget);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < n_en && cyc < budget) begin
      ena = ($urandom_range(0, 3) != 0);
      if (ena) got++;
      tick(1);
      cyc++;
    end
    ena = 1'b1;
    check("rand_enabled_budget", int'(got >= n_en), 1);
  endtask

  initial begin
    int cyc, seen, held, prev_x, prev_y;

    vecs[0]  = '{1'b1,  10,  21, 'hF800,  30, 16, 4808};
    vecs[1]  = '{1'b1,  10,  21, 'hF800, 100,  0,    0};
    vecs[2]  = '{1'b1,  12,  22, 'h07E0,  30, 16, 4812};
    vecs[3]  = '{1'b1, 300,   5, 'hFFFF,  30,  0,    0};
    vecs[4]  = '{1'b1,   5, 320, 'hFFFF,  30,  0,    0};
    vecs[5]  = '{1'b1,   5,  40, 'hFFFF,  30,  0,    0};
    vecs[6]  = '{1'b1,  12,  22, 'h07E0,  30,  0,    0};
    vecs[7]  = '{1'b0,  12,  22, 'h0000,  30,  0,    0};
    vecs[8]  = '{1'b1,  13,  23, 'h001F,  30, 16, 4812};
    vecs[9]  = '{1'b1, 239,  39, 'hABCD,  30, 16, 8876};
    vecs[10] = '{1'b1,   0,   0, 'h1234,  30, 16,    0};

    drive_touch(1'b0, 0, 0, 0, 1'b0);
    tick(3);
    check("rst_wr_ena", int'(vram_wr_ena), 0);
    check("rst_wr_addr", int'(vram_wr_addr), 0);
    check("rst_wr_data", int'(vram_wr_data), 0);
    check("rst_busy", int'(busy), 1);

    rstb = 1'b1;
    ena  = 1'b1;
    cyc  = 0;
    while (busy && cyc < SETTLE) begin
      tick(1);
      cyc++;
    end
    check("reset_sweep_done", int'(busy), 0);
    tick(3);
    check("reset_sweep_idle_wr_ena", int'(vram_wr_ena), 0);
    add_sweep();
    check_stream("reset_sweep");

    foreach (vecs[i]) begin
      drive_touch(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].col, 1'b0);
      model_touch(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].col, 1'b0);
      seen = 0;
      for (int c = 0; c < vecs[i].hold; c++) begin
        tick(1);
        if (busy) seen = 1;
      end
      check($sformatf("vec%0d_busy_seen", i), seen, int'(vecs[i].exp_n > 0));
      check($sformatf("vec%0d_busy_end", i), int'(busy), 0);
      check($sformatf("vec%0d_n", i), obs_a.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0 && obs_a.size() > 0)
        check($sformatf("vec%0d_first", i), obs_a[0], vecs[i].exp_first);
      check_stream($sformatf("vec%0d", i));
    end

    // Clear during a paint: paint finishes, full sweep, then the still-held
    // touch repaints because the sweep forgets the last cell.
    drive_touch(1'b1, 100, 30, 'h5555, 1'b0);
    add_paint(100, 30, 'h5555);
    add_sweep();
    m_lv = 1'b0;
    model_touch(1'b1, 100, 30, 'h5555, 1'b0);
    wait_writes("clear_mid_paint", 5, 40);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(SETTLE);
    check_stream("clear_mid_paint");

    // Freeze mid-paint; a clear seen while frozen is still remembered.
    drive_touch(1'b1, 60, 12, 'h0F0F, 1'b0);
    add_paint(60, 12, 'h0F0F);
    wait_writes("ena_low", 6, 40);
    held  = exp_a[obs_a.size() - 1];
    ena   = 1'b0;
    clear = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      clear = 1'b0;
      check($sformatf("ena_low_wr_ena_%0d", c), int'(vram_wr_ena), 0);
      check($sformatf("ena_low_addr_held_%0d", c), int'(vram_wr_addr), held);
    end
    ena = 1'b1;
    add_sweep();
    m_lv = 1'b0;
    model_touch(1'b1, 60, 12, 'h0F0F, 1'b0);
    tick(SETTLE);
    check_stream("ena_low_resume");

    // Clear and a new touch in the same idle cycle: the clear wins.
    drive_touch(1'b1, 150, 4, 'hC3C3, 1'b0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    add_sweep();
    m_lv = 1'b0;
    model_touch(1'b1, 150, 4, 'hC3C3, 1'b0);
    tick(SETTLE);
    check_stream("clear_vs_touch");

    prev_x = 150;
    prev_y = 4;
    for (int s = 0; s < 40; s++) begin
      bit v;
      int x, y, col;
      v   = ($urandom_range(0, 5) != 0);
      x   = prev_x;
      y   = prev_y;
      if ($urandom_range(0, 2) != 0) begin
        x = $urandom_range(0, 300);
        y = $urandom_range(0, H + 8);
      end
      col = int'($urandom_range(0, 16'hFFFF));
      drive_touch(v, x, y, col, 1'b0);
      model_touch(v, x, y, col, 1'b0);
      run_enabled(20, 300);
      tick(2);
      check_stream($sformatf("rand%0d", s));
      prev_x = x;
      prev_y = y;
    end

`ifdef VRAM_BRUSH_PAINTER_ERASE_EN
    drive_touch(1'b0, 0, 0, 0, 1'b0);
    model_touch(1'b0, 0, 0, 0, 1'b0);
    tick(3);
    drive_touch(1'b1, 10, 21, 'hF800, 1'b0);
    model_touch(1'b1, 10, 21, 'hF800, 1'b0);
    tick(30);
    check("erase0_first", (obs_a.size() > 0) ? obs_a[0] : -1, 4808);
    check("erase0_color", (obs_d.size() > 0) ? obs_d[0] : -1, 'hF800);
    check_stream("erase0");
    drive_touch(1'b1, 10, 21, 'hF800, 1'b1);
    model_touch(1'b1, 10, 21, 'hF800, 1'b1);
    tick(30);
    check("erase1_first", (obs_a.size() > 0) ? obs_a[0] : -1, 4808);
    check("erase1_color", (obs_d.size() > 0) ? obs_d[0] : -1, 0);
    check_stream("erase1");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
